// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes engine: LANES S-boxes rewrite the 128-bit state in place, 16/LANES cycles per block.
// Optional macro SUBBYTES_INV_EN adds a per-lane inverse S-box chosen by the inv bit latched with the block.
module subbytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int SW   = 8 * LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gBadLanes
    $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    data_q, data_d;
  logic [6:0]      byteBase;
  logic [SW-1:0]   laneIn;
  logic [SW-1:0]   laneOut;

  // Each table row holds 16 results for one high nibble, leftmost byte = low nibble 0.
  function automatic logic [7:0] sboxFwd(input logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

`ifdef SUBBYTES_INV_EN
  function automatic logic [7:0] sboxInv(input logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

  logic inv_q, inv_d;
`else
  logic unusedInv;
  assign unusedInv = inv;
`endif

  assign byteBase = 7'(cnt_q * SW);
  assign laneIn   = data_q[byteBase +: SW];

  for (genvar l = 0; l < LANES; l++) begin : gLane
`ifdef SUBBYTES_INV_EN
    assign laneOut[8*l +: 8] = inv_q ? sboxInv(laneIn[8*l +: 8]) : sboxFwd(laneIn[8*l +: 8]);
`else
    assign laneOut[8*l +: 8] = sboxFwd(laneIn[8*l +: 8]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef SUBBYTES_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef SUBBYTES_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // The last RUN edge parks the counter at zero so DONE/IDLE never see a wrapped value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef SUBBYTES_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
`ifdef SUBBYTES_INV_EN
          inv_d   = inv;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        data_d[byteBase +: SW] = laneOut;
        if (cnt_q == CW'(NCYC - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_subbytes_iter.sv
// Self-checking bench for subbytes_iter: three instances (LANES 4, 1, 16) against a GF(2^8) arithmetic S-box model.
// Honours SUBBYTES_INV_EN: with it the inverse table is expected, without it inv must be ignored.
module tb_subbytes_iter;

  localparam int NDUT = 3;
`ifdef SUBBYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstN;
  logic [NDUT-1:0]   inValid, inReady, invIn, outValid, outReady, busy;
  logic [127:0]      inData  [NDUT];
  logic [127:0]      outData [NDUT];
  logic [7:0]        fwdTab  [256];
  logic [7:0]        invTab  [256];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  // Instance 0 uses LANES=4, instance 1 LANES=1, instance 2 LANES=16
  for (genvar g = 0; g < NDUT; g++) begin : gDut
    subbytes_iter #(.LANES(g == 0 ? 4 : (g == 1 ? 1 : 16))) uDut (
      .clk       (clk),
      .rst_n     (rstN),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .in_data   (inData[g]),
      .inv       (invIn[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .out_data  (outData[g]),
      .busy      (busy[g])
    );
  end

  function automatic int nCycOf(input int idx);
    return (idx == 0) ? 4 : ((idx == 1) ? 16 : 1);
  endfunction

  // AES field multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gfInvRef(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gfMul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box = affine(multiplicative inverse); the inverse S-box is the permutation inverted
  task automatic buildTables();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, y;
      x = gfInvRef(8'(i));
      y = x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
      fwdTab[i] = y;
      invTab[y] = 8'(i);
    end
  endtask

  function automatic logic [127:0] expBlock(input logic [127:0] d, input logic useInv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = (useInv && INV_EN) ? invTab[d[8*i +: 8]] : fwdTab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one block at a negedge; returns at the negedge after the accepting edge
  task automatic applyStimulus(input int idx, input logic [127:0] d, input logic invBit);
    int w;
    w = 0;
    while (!inReady[idx] && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) checkOutput("inReadyTimeout", 128'(inReady[idx]), 128'd1);
    inData[idx]  = d;
    invIn[idx]   = invBit;
    inValid[idx] = 1'b1;
    @(negedge clk);
    inValid[idx] = 1'b0;
    checkOutput("inReadyDrop", 128'(inReady[idx]), 128'd0);
  endtask

  // Runs one block up to out_valid and checks latency, busy length and the result
  task automatic runBlock(input int idx, input logic [127:0] d, input logic invBit,
                          input logic [127:0] exp, input string tag, input bit flipInv);
    int cycles, busyCnt;
    applyStimulus(idx, d, invBit);
    if (flipInv) invIn[idx] = ~invBit;
    cycles  = 0;
    busyCnt = 0;
    while (!outValid[idx] && cycles < 40) begin
      if (busy[idx]) busyCnt++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "-latency"}, 128'(cycles), 128'(nCycOf(idx)));
    checkOutput({tag, "-busyCycles"}, 128'(busyCnt), 128'(nCycOf(idx)));
    checkOutput({tag, "-data"}, outData[idx], exp);
  endtask

  task automatic finishBlock(input int idx);
    outReady[idx] = 1'b1;
    @(negedge clk);
    outReady[idx] = 1'b0;
    checkOutput("releaseOutValid", 128'(outValid[idx]), 128'd0);
    checkOutput("releaseInReady", 128'(inReady[idx]), 128'd1);
  endtask

  initial begin
    logic [127:0] d, exp;
    int           lastHit, hits, idx;
    logic         b;

    buildTables();
    rstN     = 1'b0;
    inValid  = '0;
    outReady = '0;
    invIn    = '0;
    for (int i = 0; i < NDUT; i++) inData[i] = '0;
    repeat (2) @(negedge clk);

    // Reset values on every instance
    checkOutput("rstInReady", 128'(inReady), 128'b111);
    checkOutput("rstOutValid", 128'(outValid), 128'b000);
    checkOutput("rstBusy", 128'(busy), 128'b000);
    for (int i = 0; i < NDUT; i++) checkOutput("rstOutData", outData[i], 128'd0);
    rstN = 1'b1;
    @(negedge clk);

    // All-zero block on LANES=4, and the first S-box row on LANES=1
    runBlock(0, 128'd0, 1'b0, {16{8'h63}}, "zeroL4", 1'b0);
    finishBlock(0);
    runBlock(1, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
             128'h76abd7fe2b670130c56f6bf27b777c63, "countL1", 1'b0);
    finishBlock(1);

    // Backpressure: result held for 10 cycles, a new in_valid pulse must be ignored
    d   = rand128();
    exp = expBlock(d, 1'b0);
    runBlock(0, d, 1'b0, exp, "bpL4", 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        inData[0]  = ~d;
        inValid[0] = 1'b1;
      end
      if (c == 5) inValid[0] = 1'b0;
      @(negedge clk);
      checkOutput("bpData", outData[0], exp);
      checkOutput("bpInReady", 128'(inReady[0]), 128'd0);
      checkOutput("bpOutValid", 128'(outValid[0]), 128'd1);
    end
    finishBlock(0);
    @(negedge clk);
    checkOutput("bpNoGhostAccept", 128'(busy[0]), 128'd0);

    // Reset in the second RUN cycle aborts the block immediately
    applyStimulus(0, rand128(), 1'b0);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstInReady", 128'(inReady[0]), 128'd1);
    checkOutput("midRstBusy", 128'(busy[0]), 128'd0);
    checkOutput("midRstOutValid", 128'(outValid[0]), 128'd0);
    checkOutput("midRstOutData", outData[0], 128'd0);
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("abortNoOutput", 128'(outValid[0]), 128'd0);
    end
    runBlock(0, {16{8'h53}}, 1'b0, {16{8'hed}}, "afterRst", 1'b0);
    finishBlock(0);

    // LANES=16 streaming with out_ready tied high: one block every 3 cycles
    outReady[2] = 1'b1;
    inData[2]   = {16{8'hff}};
    inValid[2]  = 1'b1;
    lastHit     = -1;
    hits        = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (outValid[2]) begin
        checkOutput("b2bData", outData[2], {16{8'h16}});
        if (lastHit >= 0) checkOutput("b2bSpacing", 128'(c - lastHit), 128'd3);
        lastHit = c;
        hits++;
      end
    end
    inValid[2]  = 1'b0;
    outReady[2] = 1'b0;
    checkOutput("b2bCount", 128'(hits), 128'd5);
    @(negedge clk);

`ifdef SUBBYTES_INV_EN
    runBlock(0, {16{8'h63}}, 1'b1, {16{8'h00}}, "inv63", 1'b0);
    finishBlock(0);
    runBlock(0, 128'd0, 1'b1, {16{8'h52}}, "inv00", 1'b0);
    finishBlock(0);
`else
    runBlock(0, 128'd0, 1'b1, {16{8'h63}}, "invIgnored", 1'b0);
    finishBlock(0);
`endif
    // inv flipped during RUN must not change the result
    d = rand128();
    runBlock(0, d, 1'b1, expBlock(d, 1'b1), "invFlipL4", 1'b1);
    finishBlock(0);
    d = rand128();
    runBlock(1, d, 1'b1, expBlock(d, 1'b1), "invFlipL1", 1'b1);
    finishBlock(1);

    // Random blocks across all instances with random consumer stalls
    for (int k = 0; k < 12; k++) begin
      idx = k % NDUT;
      d   = rand128();
      b   = 1'($urandom_range(0, 1));
      exp = expBlock(d, b);
      runBlock(idx, d, b, exp, "rand", 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        checkOutput("randHold", outData[idx], exp);
      end
      finishBlock(idx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guards against a stuck run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
